uart_rx_param: RTL and testbench

Parametrised UART receiver, successor to the fixed-rate 8-bit serial receive path. Accepts an asynchronous serial line on Rx and synchronises it to CLK. Samples each bit at OVERSAMPLE x baud with 3-sample majority voting. Supports configurable data width, parity and stop bits, and delivers each frame on a valid/ready handshake with framing, parity and overrun status.

---
 rtl/uart_rx_param_if.sv | 23 ++
 rtl/uart_rx_param.sv | 161 ++++++++++++++++
 tb/tb_uart_rx_param.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_param_if.sv
// Receive-side word interface: the receiver drives the word and its status,
// the consumer drives data_ready.
interface uart_rx_param_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] data;
    logic                 data_valid;
    logic                 data_ready;
    logic                 frame_err;
    logic                 parity_err;
    logic                 overrun;
    logic                 busy;

    modport master (
        output data, data_valid, frame_err, parity_err, overrun, busy,
        input  data_ready
    );

    modport slave (
        input  data, data_valid, frame_err, parity_err, overrun, busy,
        output data_ready
    );
endinterface

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-flop synchroniser, oversampled 3-point
// majority bit recovery, optional parity, 1-2 stop bits, valid/ready output.
//
// state | meaning
// IDLE  | line idle; waiting (armed) for a low level on rxs
// START | start bit; a high majority is a false start
// DATA  | shifting in DATA_BITS data bits, LSB first
// PAR   | parity bit
// STOP  | stop bit(s); frame completes at the last stop bit's majority point
module uart_rx_param #(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            Rx,
    uart_rx_param_if.master bus
);
    localparam int DIV_RAW = (CLK_HZ + (BAUD * OVERSAMPLE) / 2) / (BAUD * OVERSAMPLE);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int TW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SW      = $clog2(OVERSAMPLE);
    localparam int BW      = $clog2(DATA_BITS + 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t               state, next_state;
    logic                 sync_1, rxs;
    logic [TW-1:0]        tick_cnt;
    logic [SW-1:0]        samp_cnt;
    logic                 tick, at_mid, at_end, maj;
    logic                 v_lo, v_mid;
    logic [BW-1:0]        bit_cnt;
    logic [1:0]           stop_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 fe_acc, pe_acc;
    logic                 armed;
    logic                 done, done_q, start_entry;
    logic [DATA_BITS-1:0] data_r;
    logic                 dv_r, fe_r, pe_r, ovr_r;

    assign tick   = (tick_cnt == TW'(DIV - 1));
    assign at_mid = tick && (samp_cnt == SW'(OVERSAMPLE / 2 + 1));
    assign at_end = tick && (samp_cnt == SW'(OVERSAMPLE - 1));
    // third vote is the live sample taken at the majority point itself
    assign maj    = (v_lo & v_mid) | (v_lo & rxs) | (v_mid & rxs);

    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        done       = 1'b0;
        case (state)
            IDLE:  if (armed && !rxs) next_state = START;
            START: begin
                if (at_mid && maj) next_state = IDLE;
                else if (at_end)   next_state = DATA;
            end
            DATA:  if (at_end && bit_cnt == BW'(DATA_BITS))
                       next_state = (PARITY != 0) ? PAR : STOP;
            PAR:   if (at_end) next_state = STOP;
            STOP:  if (at_mid && stop_cnt == 2'(STOP_BITS - 1)) begin
                       next_state = IDLE;
                       done       = 1'b1;
                   end
            default: next_state = IDLE;
        endcase
    end

    assign start_entry = (state == IDLE) && (next_state == START);

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_1   <= 1'b1;
            rxs      <= 1'b1;
            tick_cnt <= '0;
            samp_cnt <= '0;
            v_lo     <= 1'b1;
            v_mid    <= 1'b1;
            bit_cnt  <= '0;
            stop_cnt <= '0;
            shreg    <= '0;
            fe_acc   <= 1'b0;
            pe_acc   <= 1'b0;
            armed    <= 1'b0;
            done_q   <= 1'b0;
            data_r   <= '0;
            dv_r     <= 1'b0;
            fe_r     <= 1'b0;
            pe_r     <= 1'b0;
            ovr_r    <= 1'b0;
        end else begin
            sync_1 <= Rx;
            rxs    <= sync_1;
            done_q <= done;

            if (start_entry || tick) tick_cnt <= '0;
            else                     tick_cnt <= tick_cnt + 1'b1;

            if (start_entry)  samp_cnt <= '0;
            else if (at_end)  samp_cnt <= '0;
            else if (tick)    samp_cnt <= samp_cnt + 1'b1;

            if (tick && samp_cnt == SW'(OVERSAMPLE / 2 - 1)) v_lo  <= rxs;
            if (tick && samp_cnt == SW'(OVERSAMPLE / 2))     v_mid <= rxs;

            if (start_entry) begin
                bit_cnt  <= '0;
                stop_cnt <= '0;
                fe_acc   <= 1'b0;
                pe_acc   <= 1'b0;
            end

            if (state == DATA && at_mid) begin
                shreg   <= {maj, shreg[DATA_BITS-1:1]};
                bit_cnt <= bit_cnt + 1'b1;
            end

            if (state == PAR && at_mid)
                pe_acc <= (PARITY == 1) ? ~(^shreg ^ maj) : (^shreg ^ maj);

            if (state == STOP && at_mid) begin
                fe_acc   <= fe_acc | ~maj;
                stop_cnt <= stop_cnt + 1'b1;
            end

            // a framing error (e.g. a break) must see idle high before re-arming
            if (state == IDLE && tick && rxs) armed <= 1'b1;
            if (done && (fe_acc || !maj))     armed <= 1'b0;

            if (done_q) begin
                if (!dv_r || bus.data_ready) begin
                    data_r <= shreg;
                    fe_r   <= fe_acc;
                    pe_r   <= pe_acc;
                    dv_r   <= 1'b1;
                    if (dv_r) ovr_r <= 1'b0;
                end else begin
                    ovr_r <= 1'b1;
                end
            end else if (dv_r && bus.data_ready) begin
                dv_r  <= 1'b0;
                ovr_r <= 1'b0;
            end
        end
    end

    assign bus.data       = data_r;
    assign bus.data_valid = dv_r;
    assign bus.frame_err  = fe_r;
    assign bus.parity_err = pe_r;
    assign bus.overrun    = ovr_r;
    assign bus.busy       = (state != IDLE);
endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: one 8N1 receiver and one 8E1 receiver,
// 160 clocks per bit.
module tb_uart_rx_param;
    localparam int CLK_HZ = 1600000;
    localparam int BAUD   = 10000;
    localparam int OS     = 16;
    localparam int BIT    = 160;

    logic CLK  = 1'b0;
    logic RST  = 1'b1;
    logic rx   = 1'b1;
    logic rx_e = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    uart_rx_param_if #(.DATA_BITS(8)) bif ();
    uart_rx_param_if #(.DATA_BITS(8)) bif_e ();

    uart_rx_param #(
        .CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(8),
        .PARITY(0), .STOP_BITS(1), .OVERSAMPLE(OS)
    ) dut (
        .CLK(CLK), .RST(RST), .Rx(rx), .bus(bif)
    );

    uart_rx_param #(
        .CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(8),
        .PARITY(2), .STOP_BITS(1), .OVERSAMPLE(OS)
    ) dut_e (
        .CLK(CLK), .RST(RST), .Rx(rx_e), .bus(bif_e)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic bit_out(input int sel, input logic v);
        if (sel == 0) rx = v;
        else          rx_e = v;
        repeat (BIT) @(negedge CLK);
    endtask

    task automatic frame(input int sel, input logic [8:0] v, input int n);
        bit_out(sel, 1'b0);
        for (int i = 0; i < n; i++) bit_out(sel, v[i]);
        bit_out(sel, 1'b1);
    endtask

    task automatic accept(input int sel);
        if (sel == 0) bif.data_ready = 1'b1;
        else          bif_e.data_ready = 1'b1;
        @(negedge CLK);
        bif.data_ready   = 1'b0;
        bif_e.data_ready = 1'b0;
    endtask

    initial begin
        logic busy_seen;
        logic dv_seen;

        bif.data_ready   = 1'b0;
        bif_e.data_ready = 1'b0;
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        chk("rst data",       32'(bif.data), 32'h0);
        chk("rst data_valid", 32'(bif.data_valid), 32'h0);
        chk("rst frame_err",  32'(bif.frame_err), 32'h0);
        chk("rst parity_err", 32'(bif.parity_err), 32'h0);
        chk("rst overrun",    32'(bif.overrun), 32'h0);
        chk("rst busy",       32'(bif.busy), 32'h0);
        chk("rst e valid",    32'(bif_e.data_valid), 32'h0);
        RST = 1'b0;
        repeat (30) @(negedge CLK);

        // basic 8N1 word, held until accepted
        frame(0, 9'h0A5, 8);
        repeat (4) @(negedge CLK);
        chk("a5 data",       32'(bif.data), 32'hA5);
        chk("a5 valid",      32'(bif.data_valid), 32'h1);
        chk("a5 frame_err",  32'(bif.frame_err), 32'h0);
        chk("a5 parity_err", 32'(bif.parity_err), 32'h0);
        chk("a5 busy",       32'(bif.busy), 32'h0);
        repeat (1000) @(negedge CLK);
        chk("a5 hold data",  32'(bif.data), 32'hA5);
        chk("a5 hold valid", 32'(bif.data_valid), 32'h1);
        accept(0);
        chk("a5 accepted valid", 32'(bif.data_valid), 32'h0);

        // even parity: 0x3C has four ones, so parity bit 1 is wrong
        frame(1, 9'h13C, 9);
        repeat (4) @(negedge CLK);
        chk("par1 data",       32'(bif_e.data), 32'h3C);
        chk("par1 valid",      32'(bif_e.data_valid), 32'h1);
        chk("par1 parity_err", 32'(bif_e.parity_err), 32'h1);
        chk("par1 frame_err",  32'(bif_e.frame_err), 32'h0);
        accept(1);
        frame(1, 9'h03C, 9);
        repeat (4) @(negedge CLK);
        chk("par0 data",       32'(bif_e.data), 32'h3C);
        chk("par0 valid",      32'(bif_e.data_valid), 32'h1);
        chk("par0 parity_err", 32'(bif_e.parity_err), 32'h0);
        accept(1);
        chk("par0 accepted valid", 32'(bif_e.data_valid), 32'h0);

        // false start: 40 clocks low
        busy_seen = 1'b0;
        dv_seen   = 1'b0;
        rx = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge CLK);
            if (i == 40) rx = 1'b1;
            if (i == 10) busy_seen = bif.busy;
            if (bif.data_valid) dv_seen = 1'b1;
        end
        chk("false start busy rose", 32'(busy_seen), 32'h1);
        chk("false start busy back", 32'(bif.busy), 32'h0);
        chk("false start no word",   32'(dv_seen), 32'h0);

        // back-to-back frames with no accept
        frame(0, 9'h011, 8);
        frame(0, 9'h022, 8);
        repeat (4) @(negedge CLK);
        chk("b2b data",    32'(bif.data), 32'h11);
        chk("b2b valid",   32'(bif.data_valid), 32'h1);
        chk("b2b overrun", 32'(bif.overrun), 32'h1);
        accept(0);
        chk("b2b accepted valid",   32'(bif.data_valid), 32'h0);
        chk("b2b accepted overrun", 32'(bif.overrun), 32'h0);

        // break: 12 bit times low gives one word with a framing error
        rx = 1'b0;
        repeat (12 * BIT) @(negedge CLK);
        chk("brk data",      32'(bif.data), 32'h00);
        chk("brk valid",     32'(bif.data_valid), 32'h1);
        chk("brk frame_err", 32'(bif.frame_err), 32'h1);
        chk("brk overrun",   32'(bif.overrun), 32'h0);
        chk("brk busy",      32'(bif.busy), 32'h0);
        rx = 1'b1;
        repeat (1000) @(negedge CLK);
        chk("brk after data",    32'(bif.data), 32'h00);
        chk("brk after fe",      32'(bif.frame_err), 32'h1);
        chk("brk after overrun", 32'(bif.overrun), 32'h0);
        accept(0);
        chk("brk accepted valid", 32'(bif.data_valid), 32'h0);
        repeat (20) @(negedge CLK);
        frame(0, 9'h07E, 8);
        repeat (4) @(negedge CLK);
        chk("7e data",      32'(bif.data), 32'h7E);
        chk("7e valid",     32'(bif.data_valid), 32'h1);
        chk("7e frame_err", 32'(bif.frame_err), 32'h0);
        accept(0);

        // reset during data bit 4 of 0xFF
        bit_out(0, 1'b0);
        for (int i = 0; i < 4; i++) bit_out(0, 1'b1);
        rx = 1'b1;
        repeat (80) @(negedge CLK);
        chk("mid busy before rst", 32'(bif.busy), 32'h1);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        chk("mid rst data",    32'(bif.data), 32'h0);
        chk("mid rst valid",   32'(bif.data_valid), 32'h0);
        chk("mid rst busy",    32'(bif.busy), 32'h0);
        chk("mid rst overrun", 32'(bif.overrun), 32'h0);
        chk("mid rst fe",      32'(bif.frame_err), 32'h0);
        repeat (400) @(negedge CLK);
        chk("mid no partial word", 32'(bif.data_valid), 32'h0);
        frame(0, 9'h05A, 8);
        repeat (4) @(negedge CLK);
        chk("5a data",       32'(bif.data), 32'h5A);
        chk("5a valid",      32'(bif.data_valid), 32'h1);
        chk("5a frame_err",  32'(bif.frame_err), 32'h0);
        chk("5a parity_err", 32'(bif.parity_err), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
